// File: rtl/dual_port_bram_pipe.sv
// dual_port_bram_pipe: parametrised simple dual-port block RAM (one write port,
// one read port, single clock) with byte-lane write enables, optional output
// register (OUT_REG), selectable read-during-write behaviour (COLLISION_MODE)
// and a read-data valid strobe.
// Optional macro BRAM_CLEAR_EN: adds a post-reset sweep that zeroes every
// location while busy is high; without it busy is tied low.
module dual_port_bram_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int BYTE_WIDTH     = 8,
  parameter int OUT_REG        = 0,
  parameter int COLLISION_MODE = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wen,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]            d_in,
  input  logic                             ren,
  input  logic [ADDR_WIDTH-1:0]            raddr,
  output logic [DATA_WIDTH-1:0]            d_out,
  output logic                             d_valid,
  output logic                             busy
);

  localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $error("dual_port_bram_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_outreg
    $error("dual_port_bram_pipe: OUT_REG must be 0 or 1");
  end
  if (COLLISION_MODE != 0 && COLLISION_MODE != 1) begin : g_bad_collision
    $error("dual_port_bram_pipe: COLLISION_MODE must be 0 or 1");
  end

  // Lanes with be set take the new data, the rest keep the old word.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NUM_LANES-1:0]  be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (be[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  busy_w;
  logic                  wr_en_w;
  logic                  rd_en_w;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [NUM_LANES-1:0]  mem_be;

  assign wr_en_w = wen && !busy_w;
  assign rd_en_w = ren && !busy_w;

`ifdef BRAM_CLEAR_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  busy_q;

  // Clear sweep: reset parks in CLEAR at address 0, one location zeroed per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_w = busy_q;

  // Write-port source: the sweep owns the array while clearing.
  always_comb begin
    mem_we   = wr_en_w && (|wbe);
    mem_addr = waddr;
    mem_data = d_in;
    mem_be   = wbe;
    if (state_q == S_CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_cnt_q;
      mem_data = '0;
      mem_be   = '1;
    end
  end
`else
  assign busy_w = 1'b0;

  // Write-port source: user port only.
  always_comb begin
    mem_we   = wr_en_w && (|wbe);
    mem_addr = waddr;
    mem_data = d_in;
    mem_be   = wbe;
  end
`endif

  assign busy = busy_w;

  // Array update; no write lands on an edge where reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[mem_addr] <= merge_lanes(mem_q[mem_addr], mem_data, mem_be);
    end
  end

  logic [DATA_WIDTH-1:0] s1_data_d;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic                  s1_valid_q;

  // Read mux: write-first mode forwards the merged word on an address match.
  always_comb begin
    s1_data_d = mem_q[raddr];
    if (COLLISION_MODE == 1 && wr_en_w && (waddr == raddr)) begin
      s1_data_d = merge_lanes(mem_q[raddr], d_in, wbe);
    end
  end

  // Stage 1: capture read word; data only moves on an accepted read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= rd_en_w;
      if (rd_en_w) s1_data_q <= s1_data_d;
    end
  end

  if (OUT_REG == 1) begin : g_out_reg
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;

    // Output register: extra cycle of latency, holds last word between reads.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) out_data_q <= s1_data_q;
      end
    end

    assign d_out   = out_data_q;
    assign d_valid = out_valid_q;
  end else begin : g_no_out_reg
    assign d_out   = s1_data_q;
    assign d_valid = s1_valid_q;
  end

endmodule

// File: doc/dual_port_bram_pipe.md
Name: dual_port_bram_pipe

Overview:
- Parametrised simple dual-port block RAM: one write port, one read port, single clock.
- Generalises the fixed 1024x32 dual-port RAM with:
  - configurable width and depth
  - byte-lane write enables
  - optional output pipeline register
  - defined read-during-write collision behaviour
  - a read-data valid strobe
- Used as the BRAM simulation/techmap model for OpenFPGA BRAM tiles and as a directly instantiable RAM in user designs.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be an integer multiple of BYTE_WIDTH.
- ADDR_WIDTH, 10, address width; depth = 2**ADDR_WIDTH words.
- BYTE_WIDTH, 8, bits per write-enable lane; NUM_LANES = DATA_WIDTH/BYTE_WIDTH.
- OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles.
- COLLISION_MODE, 0, 0 = read-first (old data on same-address collision); 1 = write-first (new merged data).

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rst_n, input, 1, synchronous active-low reset.
- wen, input, 1, write enable.
- waddr, input, ADDR_WIDTH, write address.
- wbe, input, NUM_LANES, byte-lane write enables; lane i covers d_in[i*BYTE_WIDTH +: BYTE_WIDTH].
- d_in, input, DATA_WIDTH, write data.
- ren, input, 1, read enable.
- raddr, input, ADDR_WIDTH, read address.
- d_out, output, DATA_WIDTH, read data.
- d_valid, output, 1, one-cycle strobe marking new data on d_out.
- busy, output, 1, high while the clear sweep runs; constant 0 when BRAM_CLEAR_EN is undefined.

Behaviour:
- Reset, sampled at posedge while rst_n=0:
  - d_out=0, d_valid=0, all internal pipeline/valid stages=0.
  - wen and ren are ignored during reset.
  - Memory array contents are not altered by reset, except as described under Optional Feature.
- Write (edge with rst_n=1, wen=1, busy=0):
  - Each lane with wbe[i]=1 is updated from d_in.
  - Lanes with wbe[i]=0 keep their previous value.
  - wen=1 with wbe all-zero is a no-op.
- Read issue (edge N with ren=1, busy=0): word at raddr captured into stage 1.
  - OUT_REG=0: d_out updates and d_valid=1 at edge N+1.
  - OUT_REG=1: stage 1 → output register; d_out/d_valid at edge N+2.
  - d_valid is high for exactly one cycle per accepted read.
  - Back-to-back reads give one result per cycle, in order.
  - d_out holds its last value when no new data arrives; it never returns to 0 except on reset.
- Collision (same edge, wen=1, ren=1, waddr==raddr):
  - COLLISION_MODE=0: returns the pre-write word.
  - COLLISION_MODE=1: returns the merged word (enabled lanes from d_in, others from the old word).
  - The memory update is identical in both modes.
- Read after write (write at edge N, read of same address at edge N+1 or later): always returns the new data.
- Address wrap: none. Every ADDR_WIDTH value is a valid location and no range check is performed.
- Reset mid-operation: any in-flight read is discarded, with no d_valid for it after reset. A write on an edge with rst_n=0 is not performed.
- Parameter check: DATA_WIDTH % BYTE_WIDTH != 0, or OUT_REG/COLLISION_MODE outside {0,1}, triggers $error at elaboration.

Optional Feature:
- Macro: BRAM_CLEAR_EN.
- Defined: a 2-state FSM (IDLE, CLEAR) with an ADDR_WIDTH-bit counter.
  - Reset forces CLEAR with counter=0 and busy=1.
  - On each edge with rst_n=1 in CLEAR, writes all-zero to address=counter, then increments the counter.
  - After address 2**ADDR_WIDTH-1 is written, moves to IDLE with busy=0; the sweep takes 2**ADDR_WIDTH cycles after rst_n rises.
  - While busy=1, wen/ren are ignored and d_valid stays 0.
  - Reset asserted during CLEAR restarts the sweep at address 0.
- Undefined: no FSM; busy tied 0; memory power-up contents are X in simulation.

Test Plan:
- Basic write/read (OUT_REG=0): write 0xDEADBEEF at addr 5 (wbe=4'hF), then ren at addr 5 at edge N → d_out=0xDEADBEEF, d_valid=1 at edge N+1 only.
- Byte lanes: addr 7 holds 0x11223344; write d_in=0xAABBCCDD, wbe=4'b0101 → reading addr 7 returns 0x11BB33DD.
- Collision: addr 3 holds 0x00000001; same-cycle write 0x12345678 (wbe=4'hF) and read of addr 3 → returns 0x00000001 with COLLISION_MODE=0 and 0x12345678 with COLLISION_MODE=1; the next read returns 0x12345678 in both modes.
- Pipeline (OUT_REG=1): reads of addrs 0,1,2 on consecutive edges N..N+2 → d_valid high at N+2..N+4, data in order.
- Reset mid-read: ren at edge N, rst_n=0 at edge N+1 → d_valid stays 0 and d_out=0 after reset; a write presented with rst_n=0 leaves memory unchanged.
- BRAM_CLEAR_EN (ADDR_WIDTH=4): preload addr 9 with 0xFFFFFFFF, pulse reset → busy=1 for exactly 16 cycles, reads during busy give no d_valid; afterwards addr 9 reads 0x00000000.
